// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared constants and encodings for the SHA-256 message padder.
//   BLOCK_W     : SHA-256 block width in bits
//   LEN_W       : width of the trailing message-length field in bits
//   PAD_BYTE    : first padding byte appended after the message
//   BLOCK_BYTES : bytes per block
//   IDX_W       : byte index width (6 bits of position plus a "block full" bit)
//   state_t     : padder FSM states
//   pad_mode_t  : block formatting modes used by sha256_pad_fmt
// ---------------------------------------------------------------------------
package sha256_pkg;

   localparam int         BLOCK_W     = 512;
   localparam int         LEN_W       = 64;
   localparam logic [7:0] PAD_BYTE    = 8'h80;
   localparam int         BLOCK_BYTES = BLOCK_W / 8;
   localparam int         IDX_W       = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PAD,
      ST_SEND,
      ST_WAIT
   } state_t;

   typedef enum logic [1:0] {
      PM_FINAL_IN_PLACE,  // data, 0x80, zeros, length: the only/last block
      PM_SPLIT_FIRST,     // data, 0x80, zeros: length does not fit, goes to extra block
      PM_EXTRA_LEN_ONLY,  // zeros, length: extra block after a split
      PM_EXTRA_80_LEN     // 0x80, zeros, length: extra block after an exactly full block
   } pad_mode_t;

endpackage

// File: rtl/sha256_pad_fmt.sv
// ---------------------------------------------------------------------------
// sha256_pad_fmt
// Combinational block formatter. Builds a padded 512-bit block from the byte
// buffer according to the selected padding mode.
// Ports:
//   idx     in  IDX_W    number of valid message bytes in blk_in
//   bcnt    in  BCNT_W   total message byte count (bit length = bcnt*8)
//   blk_in  in  BLOCK_W  byte buffer, byte 0 in the top bits
//   mode    in  2        pad_mode_t formatting mode
//   blk_out out BLOCK_W  formatted block
// ---------------------------------------------------------------------------
module sha256_pad_fmt
   import sha256_pkg::*;
#(
   parameter int BCNT_W = 61
)
(
   input  logic [IDX_W-1:0]   idx,
   input  logic [BCNT_W-1:0]  bcnt,
   input  logic [BLOCK_W-1:0] blk_in,
   input  logic [1:0]         mode,
   output logic [BLOCK_W-1:0] blk_out
);

   logic [LEN_W-1:0] bit_len;

   always_comb begin
      bit_len = LEN_W'({bcnt, 3'b000});
      blk_out = '0;
      // Message bytes below idx are kept, the byte at idx becomes 0x80 and
      // everything above is zero. In final-in-place mode idx <= 55, so the
      // length field written below never overlaps message data.
      if (mode == PM_FINAL_IN_PLACE || mode == PM_SPLIT_FIRST) begin
         for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (IDX_W'(i) < idx) begin
               blk_out[BLOCK_W-1-8*i -: 8] = blk_in[BLOCK_W-1-8*i -: 8];
            end else if (IDX_W'(i) == idx) begin
               blk_out[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
            end
         end
      end
      if (mode == PM_EXTRA_80_LEN) begin
         blk_out[BLOCK_W-1 -: 8] = PAD_BYTE;
      end
      if (mode != PM_SPLIT_FIRST) begin
         blk_out[LEN_W-1:0] = bit_len;
      end
   end

endmodule

// File: rtl/sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// sha256_msg_padder
// Producer side of the SHA-256 core block interface. Collects a byte stream,
// applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length)
// and hands 512-bit blocks to the core one at a time, waiting for the core's
// done pulse between blocks.
// Ports:
//   Clk          in   1    clock, rising edge
//   Rst          in   1    asynchronous reset, active-low
//   i_Byte       in   8    message byte
//   i_fValid     in   1    i_Byte valid, accepted when o_fReady is high
//   i_fLast      in   1    end of message (with or without a byte)
//   o_fReady     out  1    padder accepts a byte / end-of-message
//   o_Block      out  512  block to core, byte 0 in [511:504]
//   o_fStart     out  1    one-cycle start pulse to core
//   o_fFirst     out  1    o_Block is the first block of a message
//   i_fCoreDone  in   1    core finished the current block
//   o_fMsgDone   out  1    one-cycle pulse: final block of message finished
// ---------------------------------------------------------------------------
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int BCNT_W = 61
)
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic [7:0]         i_Byte,
   input  logic               i_fValid,
   input  logic               i_fLast,
   output logic               o_fReady,
   output logic [BLOCK_W-1:0] o_Block,
   output logic               o_fStart,
   output logic               o_fFirst,
   input  logic               i_fCoreDone,
   output logic               o_fMsgDone
);

   state_t             state, state_d;
   logic [BLOCK_W-1:0] blk_buf, blk_buf_d;
   logic [BLOCK_W-1:0] fmt_blk;
   logic [IDX_W-1:0]   idx, idx_d;
   logic [BCNT_W-1:0]  bcnt, bcnt_d;
   logic               first, first_d;
   logic               fin, fin_d;      // block in flight is the last one
   logic               extra, extra_d;  // an extra length block is still owed
   logic [1:0]         xmode, xmode_d;  // format of the owed extra block
   logic [1:0]         fmt_mode;

   // In PAD the mode follows how full the buffer is; in WAIT the formatter
   // builds the owed extra block.
   always_comb begin
      if (state == ST_PAD) begin
         fmt_mode = (idx <= IDX_W'(55)) ? PM_FINAL_IN_PLACE : PM_SPLIT_FIRST;
      end else begin
         fmt_mode = xmode;
      end
   end

   sha256_pad_fmt #(
      .BCNT_W (BCNT_W)
   ) u_pad_fmt (
      .idx     (idx),
      .bcnt    (bcnt),
      .blk_in  (blk_buf),
      .mode    (fmt_mode),
      .blk_out (fmt_blk)
   );

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state   <= ST_IDLE;
         blk_buf <= '0;
         idx     <= '0;
         bcnt    <= '0;
         first   <= 1'b0;
         fin     <= 1'b0;
         extra   <= 1'b0;
         xmode   <= PM_EXTRA_LEN_ONLY;
      end else begin
         state   <= state_d;
         blk_buf <= blk_buf_d;
         idx     <= idx_d;
         bcnt    <= bcnt_d;
         first   <= first_d;
         fin     <= fin_d;
         extra   <= extra_d;
         xmode   <= xmode_d;
      end
   end

   always_comb begin
      state_d    = state;
      blk_buf_d  = blk_buf;
      idx_d      = idx;
      bcnt_d     = bcnt;
      first_d    = first;
      fin_d      = fin;
      extra_d    = extra;
      xmode_d    = xmode;
      o_fReady   = 1'b0;
      o_fStart   = 1'b0;
      o_fMsgDone = 1'b0;

      case (state)
         ST_IDLE: begin
            first_d = 1'b1;
            idx_d   = '0;
            bcnt_d  = '0;
            fin_d   = 1'b0;
            extra_d = 1'b0;
            state_d = ST_LOAD;
         end

         ST_LOAD: begin
            o_fReady = 1'b1;
            if (i_fValid) begin
               blk_buf_d[BLOCK_W-1-8*int'(idx[5:0]) -: 8] = i_Byte;
               idx_d  = idx + IDX_W'(1);
               bcnt_d = bcnt + BCNT_W'(1);
            end
            // A last byte landing in slot 63 still goes through PAD so the
            // full buffer is followed by an 0x80/length block.
            if (i_fLast) begin
               state_d = ST_PAD;
            end else if (i_fValid && idx == IDX_W'(63)) begin
               fin_d   = 1'b0;
               extra_d = 1'b0;
               state_d = ST_SEND;
            end
         end

         ST_PAD: begin
            if (idx <= IDX_W'(55)) begin
               blk_buf_d = fmt_blk;
               fin_d     = 1'b1;
               extra_d   = 1'b0;
            end else if (idx <= IDX_W'(63)) begin
               blk_buf_d = fmt_blk;
               fin_d     = 1'b0;
               extra_d   = 1'b1;
               xmode_d   = PM_EXTRA_LEN_ONLY;
            end else begin
               fin_d     = 1'b0;
               extra_d   = 1'b1;
               xmode_d   = PM_EXTRA_80_LEN;
            end
            state_d = ST_SEND;
         end

         ST_SEND: begin
            o_fStart = 1'b1;
            state_d  = ST_WAIT;
         end

         ST_WAIT: begin
            if (i_fCoreDone) begin
               first_d = 1'b0;
               if (extra) begin
                  blk_buf_d = fmt_blk;
                  extra_d   = 1'b0;
                  fin_d     = 1'b1;
                  state_d   = ST_SEND;
               end else if (fin) begin
                  o_fMsgDone = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = ST_LOAD;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_Block  = blk_buf;
   assign o_fFirst = first && (state == ST_SEND || state == ST_WAIT);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_padder
// Directed bench for sha256_msg_padder. A reference padder builds expected
// blocks from the message bytes; a monitor pops them on every o_fStart and a
// simple core model answers each block with i_fCoreDone after core_delay
// cycles, checking that the block is held meanwhile.
// ---------------------------------------------------------------------------
module tb_sha256_msg_padder;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
   localparam int           LIM       = 400;

   logic         Clk = 1'b0;
   logic         Rst;
   logic [7:0]   i_Byte;
   logic         i_fValid;
   logic         i_fLast;
   logic         o_fReady;
   logic [511:0] o_Block;
   logic         o_fStart;
   logic         o_fFirst;
   logic         i_fCoreDone;
   logic         o_fMsgDone;

   int n_checks     = 0;
   int n_pass       = 0;
   int core_delay   = 2;
   int msg_done_cnt = 0;
   int start_cnt    = 0;

   logic [511:0] exp_blk_q[$];
   logic         exp_first_q[$];
   logic [7:0]   msg_q[$];

   always #5 Clk = ~Clk;

   sha256_msg_padder dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .i_Byte      (i_Byte),
      .i_fValid    (i_fValid),
      .i_fLast     (i_fLast),
      .o_fReady    (o_fReady),
      .o_Block     (o_Block),
      .o_fStart    (o_fStart),
      .o_fFirst    (o_fFirst),
      .i_fCoreDone (i_fCoreDone),
      .o_fMsgDone  (o_fMsgDone)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference padding straight from FIPS 180-4 on the whole message.
   task automatic model_push(input int max_blk);
      logic [7:0]   p[$];
      logic [63:0]  len;
      logic [511:0] b;
      int           nblk;
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      len = 64'(msg_q.size()) * 64'd8;
      for (int k = 7; k >= 0; k--) p.push_back(len[8*k +: 8]);
      nblk = p.size() / 64;
      for (int j = 0; j < nblk && j < max_blk; j++) begin
         for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[64*j+i];
         exp_blk_q.push_back(b);
         exp_first_q.push_back(j == 0);
      end
   endtask

   task automatic set_msg_fill(input int n, input logic [7:0] v);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(v);
   endtask

   task automatic set_msg_seq(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
   endtask

   task automatic set_msg_abc();
      msg_q.delete();
      msg_q.push_back(8'h61);
      msg_q.push_back(8'h62);
      msg_q.push_back(8'h63);
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_item(input logic valid, input logic [7:0] b, input logic last);
      int n = 0;
      i_Byte   = b;
      i_fValid = valid;
      i_fLast  = last;
      while (o_fReady !== 1'b1 && n < LIM) begin
         @(negedge Clk);
         n++;
      end
      if (n >= LIM) check("ready_timeout", 512'(o_fReady), 512'd1);
      @(negedge Clk);
      i_fValid = 1'b0;
      i_fLast  = 1'b0;
   endtask

   task automatic send_msg();
      if (msg_q.size() == 0) begin
         send_item(1'b0, 8'h00, 1'b1);
      end else begin
         for (int i = 0; i < msg_q.size(); i++) send_item(1'b1, msg_q[i], i == msg_q.size() - 1);
      end
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (msg_done_cnt < target && n < LIM) begin
         @(negedge Clk);
         n++;
      end
      check("msg_done_count", 512'(msg_done_cnt), 512'(target));
   endtask

   // Block monitor / scoreboard.
   initial begin : monitor
      logic [511:0] eb;
      logic         ef;
      forever begin
         @(negedge Clk);
         if (o_fStart === 1'b1) begin
            start_cnt++;
            check("start_expected", 512'(exp_blk_q.size() > 0), 512'd1);
            if (exp_blk_q.size() > 0) begin
               eb = exp_blk_q.pop_front();
               ef = exp_first_q.pop_front();
               check("block", o_Block, eb);
               check("first", 512'(o_fFirst), 512'(ef));
            end
         end
      end
   end

   // Core model: answers each block after core_delay WAIT cycles.
   initial begin : core_model
      logic [511:0] held;
      logic         held_first;
      logic         hold_ok;
      logic         aborted;
      i_fCoreDone = 1'b0;
      forever begin
         @(negedge Clk);
         i_fCoreDone = 1'b0;
         if (o_fStart === 1'b1 && Rst === 1'b1) begin
            held       = o_Block;
            held_first = o_fFirst;
            hold_ok    = 1'b1;
            aborted    = 1'b0;
            for (int k = 0; k < core_delay; k++) begin
               @(negedge Clk);
               if (Rst !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (o_fStart !== 1'b0 || o_fReady !== 1'b0 || o_Block !== held ||
                   o_fFirst !== held_first) hold_ok = 1'b0;
            end
            if (!aborted) begin
               check("hold_in_wait", 512'(hold_ok), 512'd1);
               i_fCoreDone = 1'b1;
               #1;
               if (o_fMsgDone === 1'b1) msg_done_cnt++;
            end
         end
      end
   end

   initial begin : stimulus
      int s0;
      int n;
      Rst      = 1'b0;
      i_Byte   = 8'h00;
      i_fValid = 1'b0;
      i_fLast  = 1'b0;
      repeat (2) @(negedge Clk);
      check("rst_ready", 512'(o_fReady), 512'd0);
      check("rst_block", o_Block, 512'd0);
      check("rst_start", 512'(o_fStart), 512'd0);
      check("rst_first", 512'(o_fFirst), 512'd0);
      check("rst_msgdone", 512'(o_fMsgDone), 512'd0);
      Rst = 1'b1;

      // "abc"
      set_msg_abc();
      exp_blk_q.push_back(ABC_BLK);
      exp_first_q.push_back(1'b1);
      send_msg();
      wait_done(1);

      // empty message
      msg_q.delete();
      exp_blk_q.push_back(EMPTY_BLK);
      exp_first_q.push_back(1'b1);
      send_msg();
      wait_done(2);

      // 55 bytes: last size that fits length in the same block
      set_msg_fill(55, 8'h61);
      model_push(8);
      send_msg();
      wait_done(3);

      // 56 bytes: length spills into a second block
      set_msg_fill(56, 8'h61);
      model_push(8);
      send_msg();
      wait_done(4);

      // 64 bytes with a slow core: second block must wait for the first done
      core_delay = 10;
      set_msg_seq(64);
      model_push(8);
      send_msg();
      wait_done(5);

      // 70 bytes: a full data block sent without i_fLast, then the tail
      core_delay = 3;
      set_msg_seq(70);
      model_push(8);
      send_msg();
      wait_done(6);

      // long core latency with bytes offered while not ready
      core_delay = 80;
      set_msg_abc();
      exp_blk_q.push_back(ABC_BLK);
      exp_first_q.push_back(1'b1);
      send_msg();
      i_Byte   = 8'hEE;
      i_fValid = 1'b1;
      wait_done(7);
      i_fValid = 1'b0;
      core_delay = 2;
      set_msg_abc();
      exp_blk_q.push_back(ABC_BLK);
      exp_first_q.push_back(1'b1);
      send_msg();
      wait_done(8);

      // reset during WAIT of block 1 of a two-block message
      core_delay = 50;
      set_msg_seq(64);
      model_push(1);
      s0 = start_cnt;
      send_msg();
      n = 0;
      while (start_cnt == s0 && n < LIM) begin
         @(negedge Clk);
         n++;
      end
      check("abort_block1_started", 512'(start_cnt), 512'(s0 + 1));
      repeat (5) @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("abort_ready", 512'(o_fReady), 512'd0);
      check("abort_block", o_Block, 512'd0);
      check("abort_start", 512'(o_fStart), 512'd0);
      check("abort_first", 512'(o_fFirst), 512'd0);
      check("abort_msgdone", 512'(o_fMsgDone), 512'd0);
      repeat (3) @(negedge Clk);
      Rst = 1'b1;
      core_delay = 2;
      repeat (4) @(negedge Clk);
      check("abort_no_restart", 512'(start_cnt), 512'(s0 + 1));
      set_msg_abc();
      exp_blk_q.push_back(ABC_BLK);
      exp_first_q.push_back(1'b1);
      send_msg();
      wait_done(9);

      repeat (5) @(negedge Clk);
      check("exp_queue_empty", 512'(exp_blk_q.size()), 512'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
